// File: rtl/axi4lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
// Contents: the resp_t response encoding, and idx_lsb(), which returns the
//   address bit where the register index starts for a given data width.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  // Byte-offset bits below the register index (2 for 32-bit, 3 for 64-bit).
  function automatic int idx_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi4lite_chan_buf.sv
// One-deep valid/ready holding buffer for a single AXI channel payload.
// Ports: clk_i/rst_i clock and async reset; en_i gates acceptance; in_vld_i/in_rdy_o/in_dat_i
//   upstream handshake; full_o/dat_o held payload; pop_i empties the buffer (only when full).
module axi4lite_chan_buf #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         full_o,
  output logic [W-1:0] dat_o,
  input  logic         pop_i
);

  logic         full_q;
  logic [W-1:0] dat_q;

  // Fill and pop are mutually exclusive: fill needs empty, pop needs full.
  assign in_rdy_o = en_i && !full_q;
  assign full_o   = full_q;
  assign dat_o    = dat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      dat_q  <= '0;
    end else if (in_vld_i && in_rdy_o) begin
      full_q <= 1'b1;
      dat_q  <= in_dat_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axi4lite_regbank.sv
// Parametrised AXI4-Lite slave register bank with byte strobes, read-only registers,
//   SLVERR decode and per-register write pulses; AW and W are buffered independently.
// Ports: A_CLK/A_RST; AXI4-Lite AW/W/B/AR/R channels; REG_Q register contents;
//   HW_IN values returned for read-only registers; WR_PULSE one-cycle per-register write strobe.
module axi4lite_regbank
  import axi4lite_pkg::*;
#(
  parameter int                   DATA_W   = 32,
  parameter int                   ADDR_W   = 32,
  parameter int                   NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
  parameter logic [DATA_W-1:0]    RST_VAL  = '0
) (
  input  logic                         A_CLK,
  input  logic                         A_RST,
  input  logic                         AW_VALID,
  output logic                         AW_READY,
  input  logic [ADDR_W-1:0]            AW_ADDR,
  input  logic                         W_VALID,
  output logic                         W_READY,
  input  logic [DATA_W-1:0]            W_DATA,
  input  logic [DATA_W/8-1:0]          W_STRB,
  output logic                         B_VALID,
  input  logic                         B_READY,
  output logic [1:0]                   B_RESP,
  input  logic                         AR_VALID,
  output logic                         AR_READY,
  input  logic [ADDR_W-1:0]            AR_ADDR,
  output logic                         R_VALID,
  input  logic                         R_READY,
  output logic [DATA_W-1:0]            R_DATA,
  output logic [1:0]                   R_RESP,
  output logic [NUM_REGS*DATA_W-1:0]   REG_Q,
  input  logic [NUM_REGS*DATA_W-1:0]   HW_IN,
  output logic [NUM_REGS-1:0]          WR_PULSE
);

  localparam int LSB    = idx_lsb(DATA_W);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Word address below NUM_REGS covers both "bits above the index field" and
  // non-power-of-two register counts.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a >> LSB) < ADDR_W'(NUM_REGS);
  endfunction

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic                run_q;
  logic                b_valid_q, r_valid_q;
  resp_t               b_resp_q, r_resp_q;
  logic [DATA_W-1:0]   r_data_q;
  logic [NUM_REGS-1:0] wr_pulse_q;

  logic                      aw_full, w_full, commit;
  logic [ADDR_W-1:0]         aw_addr;
  logic [STRB_W+DATA_W-1:0]  w_buf;
  logic [DATA_W-1:0]         w_data;
  logic [STRB_W-1:0]         w_strb;
  logic [IDX_W-1:0]          aw_idx, ar_idx;
  logic                      wr_ok, ar_hs;
  logic [DATA_W-1:0]         rd_data_d;
  resp_t                     rd_resp_d;

  // Readies stay low during reset and for the first cycle after release.
  axi4lite_chan_buf #(.W(ADDR_W)) u_aw_buf (
    .clk_i(A_CLK), .rst_i(A_RST), .en_i(run_q),
    .in_vld_i(AW_VALID), .in_rdy_o(AW_READY), .in_dat_i(AW_ADDR),
    .full_o(aw_full), .dat_o(aw_addr), .pop_i(commit)
  );

  axi4lite_chan_buf #(.W(STRB_W + DATA_W)) u_w_buf (
    .clk_i(A_CLK), .rst_i(A_RST), .en_i(run_q),
    .in_vld_i(W_VALID), .in_rdy_o(W_READY), .in_dat_i({W_STRB, W_DATA}),
    .full_o(w_full), .dat_o(w_buf), .pop_i(commit)
  );

  assign {w_strb, w_data} = w_buf;
  assign commit   = aw_full && w_full && (!b_valid_q || B_READY);
  assign aw_idx   = aw_addr[LSB +: IDX_W];
  assign ar_idx   = AR_ADDR[LSB +: IDX_W];
  assign wr_ok    = addr_ok(aw_addr) && !RO_MASK[aw_idx];
  assign AR_READY = run_q && (!r_valid_q || R_READY);
  assign ar_hs    = AR_VALID && AR_READY;

  always_comb begin
    rd_data_d = '0;
    rd_resp_d = SLVERR;
    if (addr_ok(AR_ADDR)) begin
      rd_resp_d = OKAY;
      rd_data_d = RO_MASK[ar_idx] ? HW_IN[ar_idx*DATA_W +: DATA_W] : regs_q[ar_idx];
    end
  end

  // Read sampling uses regs_q before this edge's write lands, so a same-edge
  // read of the written register returns the old value.
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      regs_q     <= {NUM_REGS{RST_VAL}};
      run_q      <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= OKAY;
      r_valid_q  <= 1'b0;
      r_resp_q   <= OKAY;
      r_data_q   <= '0;
      wr_pulse_q <= '0;
    end else begin
      run_q      <= 1'b1;
      wr_pulse_q <= '0;
      if (b_valid_q && B_READY) b_valid_q <= 1'b0;
      if (commit) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_ok ? OKAY : SLVERR;
        if (wr_ok) begin
          wr_pulse_q[aw_idx] <= 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) regs_q[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end
      if (r_valid_q && R_READY) r_valid_q <= 1'b0;
      if (ar_hs) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_data_d;
        r_resp_q  <= rd_resp_d;
      end
    end
  end

  assign B_VALID  = b_valid_q;
  assign B_RESP   = b_resp_q;
  assign R_VALID  = r_valid_q;
  assign R_DATA   = r_data_q;
  assign R_RESP   = r_resp_q;
  assign REG_Q    = regs_q;
  assign WR_PULSE = wr_pulse_q;

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Directed bench for axi4lite_regbank (32-bit, 16 regs, reg 3 read-only).
// Stimulus pushes expected B/R responses into queues; negedge monitors pop and compare.
module tb_axi4lite_regbank;

  logic         A_CLK = 0;
  logic         A_RST = 1;
  logic         AW_VALID = 0, W_VALID = 0, AR_VALID = 0;
  logic         B_READY = 1, R_READY = 1;
  logic [31:0]  AW_ADDR = 0, AR_ADDR = 0, W_DATA = 0;
  logic [3:0]   W_STRB = 0;
  logic         AW_READY, W_READY, AR_READY, B_VALID, R_VALID;
  logic [1:0]   B_RESP, R_RESP;
  logic [31:0]  R_DATA;
  logic [511:0] REG_Q, HW_IN;
  logic [15:0]  WR_PULSE;

  axi4lite_regbank #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(16), .RO_MASK(16'h0008), .RST_VAL(32'h0)) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
    .REG_Q(REG_Q), .HW_IN(HW_IN), .WR_PULSE(WR_PULSE)
  );

  always #5 A_CLK = ~A_CLK;

  int checks = 0, failures = 0, b_seen = 0;
  logic [1:0]  b_exp[$];
  logic [33:0] r_exp[$];
  logic [31:0] mdl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge A_CLK) begin
    if (B_VALID && B_READY) begin
      if (b_exp.size() == 0) chk("b_unexpected", 64'(B_RESP), 64'hx);
      else chk("b_resp", 64'(B_RESP), 64'(b_exp.pop_front()));
      b_seen++;
    end
    if (R_VALID && R_READY) begin
      if (r_exp.size() == 0) chk("r_unexpected", 64'({R_RESP, R_DATA}), 64'hx);
      else chk("r_data_resp", 64'({R_RESP, R_DATA}), 64'(r_exp.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge A_CLK);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a);
    logic ok = 0;
    AW_VALID = 1; AW_ADDR = a;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge A_CLK); ok = AW_READY;
      @(posedge A_CLK); #1;
    end
    AW_VALID = 0;
    if (!ok) chk("aw_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    logic ok = 0;
    W_VALID = 1; W_DATA = d; W_STRB = s;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge A_CLK); ok = W_READY;
      @(posedge A_CLK); #1;
    end
    W_VALID = 0;
    if (!ok) chk("w_timeout", 0, 1);
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] resp);
    b_exp.push_back(resp);
    if (resp == 2'b00)
      for (int b = 0; b < 4; b++) if (s[b]) mdl[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    logic ok = 0;
    r_exp.push_back({resp, d});
    AR_VALID = 1; AR_ADDR = a;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge A_CLK); ok = AR_READY;
      @(posedge A_CLK); #1;
    end
    AR_VALID = 0;
    if (!ok) chk("ar_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && (b_exp.size() != 0 || r_exp.size() != 0); n++) idle(1);
    chk("drain_empty", 64'(b_exp.size() + r_exp.size()), 0);
  endtask

  initial begin
    int b0;
    HW_IN = '0;
    for (int i = 0; i < 16; i++) HW_IN[i*32 +: 32] = 32'hDEAD0000 | i;
    HW_IN[3*32 +: 32] = 32'h0000CAFE;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;

    // Reset state
    idle(2);
    chk("rst_aw_ready", 64'(AW_READY), 0);
    chk("rst_w_ready", 64'(W_READY), 0);
    chk("rst_ar_ready", 64'(AR_READY), 0);
    chk("rst_valids", 64'({B_VALID, R_VALID}), 0);
    chk("rst_pulse", 64'(WR_PULSE), 0);
    chk("rst_resp_data", 64'({B_RESP, R_RESP, R_DATA}), 0);
    A_RST = 0;
    idle(2);

    // 1: basic write/read, WR_PULSE one cycle
    write(32'h04, 32'h12345678, 4'hF, 2'b00);
    idle(1);
    chk("t1_pulse_on", 64'(WR_PULSE), 64'h0002);
    idle(1);
    chk("t1_pulse_off", 64'(WR_PULSE), 0);
    read(32'h04, 32'h12345678, 2'b00);
    drain();

    // 2: byte strobes
    write(32'h08, 32'hFFFFFFFF, 4'hF, 2'b00);
    write(32'h08, 32'hAABBCCDD, 4'h5, 2'b00);
    idle(2);
    chk("t2_reg2", 64'(REG_Q[2*32 +: 32]), 64'hFFBBFFDD);
    read(32'h08, 32'hFFBBFFDD, 2'b00);
    drain();

    // 3: W leads AW by 3 cycles
    b0 = b_seen;
    b_exp.push_back(2'b10);
    W_VALID = 1; W_DATA = 32'h33333333; W_STRB = 4'hF;
    @(posedge A_CLK); #1;
    W_VALID = 0;
    chk("t3_w_ready_low", 64'(W_READY), 0);
    idle(2);
    chk("t3_w_ready_still_low", 64'(W_READY), 0);
    chk("t3_no_b_yet", 64'(B_VALID), 0);
    send_aw(32'h0C);
    idle(4);
    chk("t3_one_b", 64'(b_seen - b0), 1);
    chk("t3_w_ready_back", 64'(W_READY), 1);

    // 4: out of range and read-only
    write(32'h40, 32'h44444444, 4'hF, 2'b10);
    idle(1);
    chk("t4_no_pulse_oor", 64'(WR_PULSE), 0);
    write(32'h0C, 32'h55555555, 4'hF, 2'b10);
    idle(1);
    chk("t4_no_pulse_ro", 64'(WR_PULSE), 0);
    read(32'h40, 32'h0, 2'b10);
    read(32'h0C, 32'h0000CAFE, 2'b00);
    drain();
    chk("t4_reg3_unchanged", 64'(REG_Q[3*32 +: 32]), 0);

    // 5: B backpressure with a second write queued
    B_READY = 0;
    write(32'h14, 32'h00000055, 4'hF, 2'b00);
    write(32'h18, 32'h00000066, 4'hF, 2'b00);
    for (int c = 0; c < 5; c++) begin
      chk("t5_b_valid", 64'(B_VALID), 1);
      chk("t5_b_resp", 64'(B_RESP), 0);
      chk("t5_aw_ready", 64'(AW_READY), 0);
      chk("t5_reg6_old", 64'(REG_Q[6*32 +: 32]), 0);
      idle(1);
    end
    B_READY = 1;
    drain();
    chk("t5_reg5", 64'(REG_Q[5*32 +: 32]), 64'h55);
    chk("t5_reg6", 64'(REG_Q[6*32 +: 32]), 64'h66);

    // 6: reset with B and R pending
    B_READY = 0; R_READY = 0;
    write(32'h10, 32'h11111111, 4'hF, 2'b00);
    read(32'h04, 32'h12345678, 2'b00);
    idle(1);
    chk("t6_pending", 64'({B_VALID, R_VALID}), 64'b11);
    A_RST = 1;
    #1;
    chk("t6_valids_drop", 64'({B_VALID, R_VALID}), 0);
    chk("t6_regs_reset", 64'(|REG_Q), 0);
    b_exp.delete(); r_exp.delete();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    B_READY = 1; R_READY = 1;
    idle(2);
    A_RST = 0;
    read(32'h08, 32'h0, 2'b00);
    write(32'h04, 32'h0BADF00D, 4'hF, 2'b00);
    idle(2);
    read(32'h04, 32'h0BADF00D, 2'b00);
    drain();

    for (int i = 0; i < 16; i++) chk($sformatf("final_reg%0d", i), 64'(REG_Q[i*32 +: 32]), 64'(mdl[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
